cic_interp_strobed: RTL

//  N-stage CIC interpolator, the stage directly downstream of the halfband interpolator in the DUC chain.

---
 rtl/cic_interp_strobed.sv | 99 +++++++++
 1 files changed

// File: rtl/cic_interp_strobed.sv
// cic_interp_strobed: strobed N-stage CIC interpolator.
// Paces upstream requests by rate and trims the gain with a rounded shift.
module cic_interp_strobed #(
  parameter int WIDTH = 18,
  parameter int N     = 4,
  parameter int ACCW  = WIDTH + (N-1)*8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [7:0]       rate,
  input  logic             stb_out,
  output logic             stb_req,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  localparam logic signed [ACCW:0] SMAX =
    {{(ACCW-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACCW:0] SMIN =
    {{(ACCW-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  logic [8:0]             rate_q;
  logic [8:0]             rate_eff;
  logic [8:0]             cnt_q;
  logic [8:0]             cnt_d;
  logic [5:0]             sh_q;
  logic [5:0]             sh_d;
  logic [WIDTH-1:0]       dout_q;
  logic [WIDTH-1:0]       dout_d;
  logic signed [ACCW-1:0] c_q [N+1];
  logic signed [ACCW-1:0] d_q [N];
  logic signed [ACCW-1:0] i_q [N];
  logic signed [ACCW:0]   acc_x;
  logic [ACCW:0]          bias;
  logic signed [ACCW:0]   rnd;
  logic                   grp0;

  function automatic logic [3:0] clog2_9(input logic [8:0] r);
    logic [3:0] k;
    k = '0;
    for (int b = 0; b < 9; b++)
      if ((9'd1 << b) < r) k = 4'(b + 1);
    return k;
  endfunction

  assign rate_eff = (rate == 8'd0) ? 9'd256 : {1'b0, rate};
  assign sh_d     = 6'((N-1) * int'(clog2_9(rate_eff)));
  assign grp0     = (cnt_q == 9'd0);
  assign cnt_d    = (cnt_q == rate_q - 9'd1) ? 9'd0 : cnt_q + 9'd1;
  assign stb_req  = enable & ~rst & stb_out & grp0;
  assign data_out = dout_q;

  // Half-LSB bias, one less for negatives, gives ties away from zero.
  always_comb begin
    acc_x = {i_q[N-1][ACCW-1], i_q[N-1]};
    bias  = '0;
    if (sh_q != 6'd0)
      bias = ((ACCW+1)'(1) << (sh_q - 6'd1))
           - (ACCW+1)'(acc_x[ACCW]);
    rnd = (acc_x + $signed(bias)) >>> sh_q;
    if (rnd > SMAX)
      dout_d = SMAX[WIDTH-1:0];
    else if (rnd < SMIN)
      dout_d = SMIN[WIDTH-1:0];
    else
      dout_d = rnd[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      rate_q <= rate_eff;
      sh_q   <= sh_d;
      cnt_q  <= '0;
      dout_q <= '0;
      for (int k = 0; k <= N; k++)
        c_q[k] <= '0;
      for (int k = 0; k < N; k++) begin
        d_q[k] <= '0;
        i_q[k] <= '0;
      end
    end else if (stb_out) begin
      cnt_q <= cnt_d;
      if (grp0) begin
        c_q[0] <= ACCW'($signed(data_in));
        for (int k = 1; k <= N; k++) begin
          c_q[k]   <= c_q[k-1] - d_q[k-1];
          d_q[k-1] <= c_q[k-1];
        end
      end
      // Zero-stuffing: the comb output enters only on group-start strobes.
      i_q[0] <= i_q[0] + (grp0 ? c_q[N] : '0);
      for (int k = 1; k < N; k++)
        i_q[k] <= i_q[k] + i_q[k-1];
      dout_q <= dout_d;
    end
  end

endmodule
